// File: rtl/dm_pkg.sv
// Shared types and constants for the data-memory responder.
// Byte lanes use active-low write enables, matching the CPU data-memory port.
package dm_pkg;

    typedef enum logic {DM_INIT, DM_READY} dm_state_t;

    localparam int DM_LANE_W = 8;
    localparam int DM_LANES  = 4;
    localparam int DM_WORD_W = DM_LANE_W * DM_LANES;

    typedef logic [DM_LANES-1:0]  dm_web_t;
    typedef logic [DM_WORD_W-1:0] dm_word_t;

    localparam dm_web_t DM_WEB_NONE = 4'hF;

    // Expand active-low lane enables into a bit mask of lanes being written.
    function automatic dm_word_t dm_lane_mask(input dm_web_t web);
        dm_word_t m;
        m = '0;
        for (int b = 0; b < DM_LANES; b++) begin
            if (!web[b]) begin
                m[b*DM_LANE_W +: DM_LANE_W] = {DM_LANE_W{1'b1}};
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/dm_byte_merge.sv
// Combinational merge of store data into an existing word under per-byte active-low enables.
// Zero latency; no flow control.
module dm_byte_merge
    import dm_pkg::*;
(
    input  logic [31:0] old_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  web_i,
    output logic [31:0] merged_o
);

    logic [31:0] lane_mask;

    assign lane_mask = dm_lane_mask(web_i);
    assign merged_o  = (old_i & ~lane_mask) | (wdata_i & lane_mask);

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder: word array, byte-masked writes, read data registered one cycle later.
// No backpressure; busy_o flags post-reset array clearing when DM_INIT_CLEAR_EN is defined.
module dm_responder
    import dm_pkg::*;
#(
    parameter int          DEPTH = 1024,
    parameter logic [31:0] BASE  = 32'h0,
    localparam int         AW    = $clog2(DEPTH)
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] dm_addr_i,
    input  logic [31:0] dm_wdata_i,
    input  logic [3:0]  dm_web_i,
    output logic [31:0] dm_rdata_o,
    output logic        busy_o,
    output logic        oor_err_o
);

`ifdef DM_INIT_CLEAR_EN
    localparam dm_state_t RESET_STATE = DM_INIT;
`else
    localparam dm_state_t RESET_STATE = DM_READY;
`endif

    logic [31:0]   mem_q [DEPTH];

    dm_state_t     state_q, state_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          oor_q, oor_d;

    logic [31:0]   off;
    logic [31:0]   off_words;
    logic          in_range;
    logic [AW-1:0] word;
    logic [31:0]   old_word;
    logic [31:0]   merged;

    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [31:0]   mem_wdat;

    // Unsigned wrap makes addresses below BASE land far out of range.
    assign off       = dm_addr_i - BASE;
    assign off_words = off >> 2;
    assign in_range  = off_words < 32'(DEPTH);
    assign word      = off_words[AW-1:0];
    assign old_word  = mem_q[word];

    // The same merged word feeds the array write and the read path, giving write-first reads.
    dm_byte_merge u_merge (
        .old_i    (old_word),
        .wdata_i  (dm_wdata_i),
        .web_i    (dm_web_i),
        .merged_o (merged)
    );

`ifdef DM_INIT_CLEAR_EN
    logic [AW-1:0] idx_q, idx_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

    assign busy_o = (state_q == DM_INIT);
`else
    assign busy_o = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        rdata_d   = '0;
        oor_d     = oor_q;
        mem_we    = 1'b0;
        mem_waddr = word;
        mem_wdat  = merged;
`ifdef DM_INIT_CLEAR_EN
        idx_d     = idx_q;
`endif
        unique case (state_q)
            DM_INIT: begin
`ifdef DM_INIT_CLEAR_EN
                mem_we    = 1'b1;
                mem_waddr = idx_q;
                mem_wdat  = '0;
                idx_d     = idx_q + 1'b1;
                if (idx_q == AW'(DEPTH - 1)) begin
                    state_d = DM_READY;
                end
`else
                state_d = DM_READY;
`endif
            end
            DM_READY: begin
                if (in_range) begin
                    rdata_d = merged;
                    mem_we  = (dm_web_i != DM_WEB_NONE);
                end else begin
                    oor_d   = 1'b1;
                end
            end
            default: state_d = RESET_STATE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= RESET_STATE;
            rdata_q <= '0;
            oor_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            oor_q   <= oor_d;
        end
    end

    // Storage carries no reset; clearing is done by the INIT sweep when enabled.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdat;
        end
    end

    assign dm_rdata_o = rdata_q;
    assign oor_err_o  = oor_q;

endmodule

// File: tb/tb_dm_responder.sv
// Randomized bench for dm_responder against a byte-level memory model with known-byte tracking.
module tb_dm_responder;

    localparam int          DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h0000_8000;
`ifdef DM_INIT_CLEAR_EN
    localparam int INIT_CYC = DEPTH;
    localparam int ABORT_EXP = 100;
`else
    localparam int INIT_CYC = 0;
    localparam int ABORT_EXP = 0;
`endif

    logic        clk;
    logic        rst_n;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_web;
    logic [31:0] dm_rdata;
    logic        busy;
    logic        oor_err;

    int n_checks;
    int n_fail;

    logic [31:0] mem_m   [DEPTH];
    logic [3:0]  known_m [DEPTH];
    logic        oor_m;
    logic [31:0] pend_rd;
    logic [31:0] pend_mask;

    dm_responder #(.DEPTH(DEPTH), .BASE(BASE)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .dm_addr_i  (dm_addr),
        .dm_wdata_i (dm_wdata),
        .dm_web_i   (dm_web),
        .dm_rdata_o (dm_rdata),
        .busy_o     (busy),
        .oor_err_o  (oor_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] byte_mask(input logic [3:0] kn);
        logic [31:0] m;
        m = '0;
        for (int b = 0; b < 4; b++) begin
            if (kn[b]) m[8*b +: 8] = 8'hFF;
        end
        return m;
    endfunction

    // Apply one access to the model and record what dm_rdata must show after the next edge.
    task automatic model_access(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
        logic [31:0] off32;
        int wi;
        off32 = a - BASE;
        if (off32 < 32'(DEPTH * 4)) begin
            wi = int'(off32 / 4);
            for (int b = 0; b < 4; b++) begin
                if (!w[b]) begin
                    mem_m[wi][8*b +: 8] = d[8*b +: 8];
                    known_m[wi][b] = 1'b1;
                end
            end
            pend_rd   = mem_m[wi];
            pend_mask = byte_mask(known_m[wi]);
        end else begin
            pend_rd   = '0;
            pend_mask = '1;
            oor_m     = 1'b1;
        end
    endtask

    task automatic step(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
        dm_addr  = a;
        dm_wdata = d;
        dm_web   = w;
        model_access(a, d, w);
        @(negedge clk);
        check("rdata", dm_rdata & pend_mask, pend_rd & pend_mask);
        check("oor", 32'(oor_err), 32'(oor_m));
        check("busy", 32'(busy), 32'd0);
    endtask

    task automatic reset_assert();
        dm_web = 4'hF;
        rst_n  = 1'b0;
        #1;
        check("rst_rdata", dm_rdata, 32'd0);
        check("rst_oor", 32'(oor_err), 32'd0);
        check("rst_busy", 32'(busy), 32'(INIT_CYC != 0));
        @(negedge clk);
        rst_n = 1'b1;
        oor_m = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (INIT_CYC != 0) begin
                mem_m[i]   = '0;
                known_m[i] = 4'hF;
            end else begin
                known_m[i] = 4'h0;
            end
        end
    endtask

    // Counts busy cycles while hammering writes (in and out of range) that must be ignored.
    task automatic init_wait(input int abort_at, output int cnt);
        cnt = 0;
        while (busy === 1'b1 && cnt < 2 * DEPTH + 8 && cnt != abort_at) begin
            dm_addr  = cnt[0] ? BASE + 32'(DEPTH * 4) : BASE + 32'h10;
            dm_wdata = 32'hFFFF_FFFF;
            dm_web   = 4'h0;
            if (cnt == DEPTH / 2) check("init_rdata", dm_rdata, 32'd0);
            @(negedge clk);
            cnt++;
        end
        dm_web = 4'hF;
    endtask

    initial begin
        int cnt;
        int r;
        logic [31:0] a;
        logic [3:0]  w;
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b1;
        dm_addr  = BASE;
        dm_wdata = '0;
        dm_web   = 4'hF;
        oor_m    = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            mem_m[i]   = '0;
            known_m[i] = 4'h0;
        end
        @(negedge clk);

        reset_assert();
        init_wait(-1, cnt);
        check("init_cycles", 32'(cnt), 32'(INIT_CYC));

        step(BASE + 32'h10, 32'h0, 4'hF);
`ifdef DM_INIT_CLEAR_EN
        check("t1_zero", dm_rdata, 32'h0);
`endif

        step(BASE + 32'h20, 32'hDEAD_BEEF, 4'h0);
        step(BASE + 32'h20, 32'h0, 4'hF);
        check("t2_full", dm_rdata, 32'hDEAD_BEEF);

        step(BASE + 32'h20, 32'h0000_AA00, 4'b1101);
        step(BASE + 32'h20, 32'h0, 4'hF);
        check("t3_lane1", dm_rdata, 32'hDEAD_AAEF);
        step(BASE + 32'h20, 32'h1122_3344, 4'b0110);
        step(BASE + 32'h20, 32'h0, 4'hF);
        check("t3_lanes03", dm_rdata, 32'h11AD_AA44);

        step(BASE + 32'h40, 32'h1234_5678, 4'h0);
        check("t4_bypass", dm_rdata, 32'h1234_5678);

        step(BASE, 32'hCAFE_F00D, 4'h0);
        step(BASE + 32'(DEPTH * 4), 32'hFFFF_FFFF, 4'h0);
        check("t5_rd_zero", dm_rdata, 32'h0);
        check("t5_oor", 32'(oor_err), 32'd1);
        step(BASE, 32'h0, 4'hF);
        check("t5_word0", dm_rdata, 32'hCAFE_F00D);
        step(BASE - 32'd4, 32'h5555_5555, 4'h0);
        for (int i = 0; i < 4; i++) step(BASE + 32'h20, 32'h0, 4'hF);

        for (int i = 0; i < 1500; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 4) a = BASE + 32'(DEPTH * 4) + ($urandom_range(0, 255) << 2);
            else if (r < 7) a = BASE - ($urandom_range(1, 64) << 2);
            else if (r < 15) a = BASE + 32'((DEPTH - 1 - int'($urandom_range(0, 3))) * 4) + $urandom_range(0, 3);
            else a = BASE + ($urandom_range(0, 31) << 2) + $urandom_range(0, 3);
            w = ($urandom_range(0, 99) < 30) ? 4'hF : 4'($urandom);
            step(a, $urandom, w);
        end

        reset_assert();
        init_wait(100, cnt);
        check("t6_abort_at", 32'(cnt), 32'(ABORT_EXP));
        reset_assert();
        init_wait(-1, cnt);
        check("t6_init_cycles", 32'(cnt), 32'(INIT_CYC));
        step(BASE + 32'h20, 32'h0, 4'hF);
        check("t6_oor_clear", 32'(oor_err), 32'd0);
`ifdef DM_INIT_CLEAR_EN
        check("t6_cleared", dm_rdata, 32'h0);
`endif
        for (int i = 0; i < 200; i++) begin
            a = BASE + ($urandom_range(0, 15) << 2);
            w = ($urandom_range(0, 99) < 30) ? 4'hF : 4'($urandom);
            step(a, $urandom, w);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
